mem_lsu: RTL and testbench

- Initiator-side load/store unit driving the single-port synchronous RAM (1-cycle read latency, whole-word write enable only).
- Accepts byte/half/word load and store requests from the core over a valid/ready channel and returns a response over a valid/ready channel.
- Implements sub-word stores as read-modify-write, sign/zero-extends loads, and rejects misaligned or out-of-range accesses without touching memory.

---
 rtl/mem_pkg.sv | 45 ++++
 rtl/mem_lane_align.sv | 47 ++++
 rtl/mem_lsu.sv | 151 +++++++++++++++
 tb/tb_mem_lsu.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and the
// latched request payload.
package mem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_W     = 8 * WORD_BYTES;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_BAD = 2'd3
  } size_t;

  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_RD    = 3'd1,
    LSU_MERGE = 3'd2,
    LSU_WR    = 3'd3,
    LSU_RESP  = 3'd4
  } lsu_state_t;

  // Request fields kept for the whole transaction (word index held separately).
  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              is_unsigned;
    logic [1:0]        off;
    logic [WORD_W-1:0] wdata;
  } lsu_req_t;

  // Size/alignment legality; range is checked by the unit that knows DEPTH.
  function automatic logic size_misaligned(logic [1:0] size, logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a RAM word and a core-side value.
//   rdata       : word read from RAM (also the "old" word for merges)
//   wdata       : right-aligned store data
//   off         : byte offset within the word (little-endian lanes)
//   size        : access size (size_t encoding)
//   is_unsigned : zero-extend loads when 1, sign-extend when 0
//   load_c      : extracted and extended load result
//   merge_c     : rdata with the addressed lane(s) replaced by wdata
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [WORD_W-1:0] rdata,
  input  logic [WORD_W-1:0] wdata,
  input  logic [1:0]        off,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [WORD_W-1:0] load_c,
  output logic [WORD_W-1:0] merge_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load extraction and extension.
  always_comb begin
    byte_sel = rdata[{off, 3'b000} +: 8];
    half_sel = rdata[{off[1], 4'b0000} +: 16];
    load_c   = rdata;
    case (size_t'(size))
      SZ_B:    load_c = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    load_c = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_c = rdata;
    endcase
  end

  // Store merge into the old word.
  always_comb begin
    merge_c = rdata;
    case (size_t'(size))
      SZ_B:    merge_c[{off, 3'b000} +: 8]     = wdata[7:0];
      SZ_H:    merge_c[{off[1], 4'b0000} +: 16] = wdata[15:0];
      SZ_W:    merge_c = wdata;
      default: merge_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of a single-port synchronous RAM (1-cycle read).
//   req_*     : core request channel (valid/ready), byte address, right-aligned data
//   rsp_*     : response channel (valid/ready), extended load data and error flag
//   mem_*     : RAM port; word index, whole-word write enable, write/read data
// Sub-word stores are read-modify-write; illegal accesses never touch memory.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [31:0]              req_addr,
  input  logic [WIDTH-1:0]         req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_rdata,
  output logic                     rsp_err,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [WIDTH-1:0]         mem_wdata,
  input  logic [WIDTH-1:0]         mem_rdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [2:0] ST_IDLE  = LSU_IDLE;
  localparam logic [2:0] ST_RD    = LSU_RD;
  localparam logic [2:0] ST_MERGE = LSU_MERGE;
  localparam logic [2:0] ST_WR    = LSU_WR;
  localparam logic [2:0] ST_RESP  = LSU_RESP;

  logic [2:0]       state_q, state_d;
  lsu_req_t         req_q;
  logic [AW-1:0]    word_q;
  logic             accept_c;
  logic             req_bad_c;
  logic             rsp_valid_d, rsp_err_d;
  logic [WIDTH-1:0] rsp_rdata_d;
  logic [WIDTH-1:0] load_c, merge_c;

  // Illegal size, misalignment or word index beyond DEPTH.
  assign req_bad_c = size_misaligned(req_size, req_addr[1:0])
                   || ({2'b00, req_addr[31:2]} >= 32'(DEPTH));

  mem_lane_align u_align (
    .rdata       (mem_rdata),
    .wdata       (req_q.wdata),
    .off         (req_q.off),
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .load_c      (load_c),
    .merge_c     (merge_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and response updates.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
    accept_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          if (req_bad_c) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (req_we && (req_size == SZ_W)) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: state_d = ST_MERGE;
      ST_MERGE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = req_q.we ? '0 : load_c;
      end
      ST_WR: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

  // Request capture on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= '0;
      word_q <= '0;
    end else if (accept_c) begin
      req_q.we          <= req_we;
      req_q.size        <= req_size;
      req_q.is_unsigned <= req_unsigned;
      req_q.off         <= req_addr[1:0];
      req_q.wdata       <= req_wdata;
      word_q            <= req_addr[2 +: AW];
    end
  end

  // Write enable is a pure state decode so reset drops it at once.
  assign mem_we    = (state_q == ST_WR) || ((state_q == ST_MERGE) && req_q.we);
  assign req_ready = (state_q == ST_IDLE);
  assign mem_addr  = word_q;
  // During MERGE the write word is the RAM read data with the new lane(s).
  assign mem_wdata = (state_q == ST_MERGE) ? merge_c : req_q.wdata;

endmodule

// File: tb/tb_mem_lsu.sv
`timescale 1ns/1ps
module tb_mem_lsu;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [31:0]   req_addr, req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ram     [DEPTH];
  logic        preload;
  logic [31:0] last_rdata, last_we_data;

  mem_lsu #(.DEPTH(DEPTH), .WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hC3A5_1E0F;
  endfunction

  // Single-port synchronous RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference lane rules expressed as shifts, masks and two's-complement arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input int sh,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    v = w >> sh;
    if (sz == 2'b00) begin
      v = v & 32'hFF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
    end else if (sz == 2'b01) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h1_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] wd,
                                            input int sh, input logic [1:0] sz);
    logic [31:0] mask;
    mask = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
    mask = mask << sh;
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  // One complete transaction; hold = cycles rsp_ready stays low after rsp_valid.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int hold);
    logic          exp_err, stable, rdy_seen;
    logic [31:0]   old, exp_rd, exp_new, r_rd, we_data;
    logic [AW-1:0] idx, we_addr;
    logic          r_err;
    int            sh, exp_lat, n, we_cnt, we_cyc;

    exp_err = (sz == 2'b11) || (sz == 2'b01 && addr[0]) ||
              (sz == 2'b10 && addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
    idx     = addr[2 +: AW];
    old     = ref_mem[idx];
    sh      = 8 * int'(addr[1:0]);
    exp_rd  = 32'h0;
    exp_new = old;
    if (!exp_err) begin
      if (we) exp_new = ref_store(old, wd, sh, sz);
      else    exp_rd  = ref_load(old, sh, sz, uns);
    end
    exp_lat = exp_err ? 1 : (we && sz == 2'b10) ? 2 : 3;

    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; rsp_ready = (hold == 0);
    @(posedge clk); #1;
    // Scramble the idle request bus: the unit must work from its latched copy.
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;

    n = 0; we_cnt = 0; we_cyc = 0; we_addr = '0; we_data = 32'h0; rdy_seen = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (req_ready) rdy_seen = 1'b1;
      if (mem_we) begin
        we_cnt++; we_cyc = n; we_addr = mem_addr; we_data = mem_wdata;
      end
    end while (!rsp_valid && n < 20);

    check_eq("rsp_latency", 32'(n), 32'(exp_lat));
    check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
    check_eq("rsp_rdata", rsp_rdata, exp_rd);
    check_eq("req_ready_busy", 32'(rdy_seen), 32'd0);
    last_rdata = rsp_rdata;

    if (hold > 0) begin
      r_rd = rsp_rdata; r_err = rsp_err; stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (!rsp_valid || rsp_rdata !== r_rd || rsp_err !== r_err || req_ready || mem_we)
          stable = 1'b0;
      end
      check_eq("bp_stable", 32'(stable), 32'd1);
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    check_eq("post_hs_valid", 32'(rsp_valid), 32'd0);
    check_eq("post_hs_ready", 32'(req_ready), 32'd1);

    check_eq("we_pulses", 32'(we_cnt), (we && !exp_err) ? 32'd1 : 32'd0);
    if (we && !exp_err) begin
      check_eq("we_addr", 32'(we_addr), 32'(idx));
      check_eq("we_data", we_data, exp_new);
      check_eq("we_cycle", 32'(we_cyc), (sz == 2'b10) ? 32'd1 : 32'd2);
      last_we_data = we_data;
      ref_mem[idx] = exp_new;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int w;
    rst_n = 1'b0; preload = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    last_rdata = 32'h0; last_we_data = 32'h0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    @(negedge clk); preload = 1'b0;
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word store then load.
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    check_eq("word_load", last_rdata, 32'hDEAD_BEEF);

    // Byte read-modify-write and byte loads.
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 0);
    do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA, 0);
    check_eq("byte_rmw_data", last_we_data, 32'h11AA_3344);
    do_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 0);
    check_eq("lb_signed", last_rdata, 32'hFFFF_FFAA);
    do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 0);
    check_eq("lb_unsigned", last_rdata, 32'h0000_00AA);

    // Half loads.
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h8001_7FFE, 0);
    do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 0);
    check_eq("lh_off2", last_rdata, 32'hFFFF_8001);
    do_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 0);
    check_eq("lh_off0", last_rdata, 32'h0000_7FFE);

    // Error cases, including stores that must not write.
    do_req(1'b0, 2'b01, 1'b0, 32'h3,    32'h0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h2,    32'h0, 0);
    do_req(1'b0, 2'b11, 1'b0, 32'h0,    32'h0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 0);
    do_req(1'b1, 2'b00, 1'b0, 32'h1000, 32'h55, 0);
    do_req(1'b1, 2'b01, 1'b0, 32'h11,   32'h55, 0);

    // Backpressure on load, store and error responses.
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5);
    do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'hBEEF, 5);
    do_req(1'b0, 2'b11, 1'b0, 32'h8,  32'h0, 5);

    // Reset while a byte store sits in RD.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h41; req_wdata = 32'h5A; rsp_ready = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; #1;
    check_eq("rstrd_mem_we", 32'(mem_we), 32'd0);
    check_eq("rstrd_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rstrd_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0);
    check_eq("rstrd_word_kept", last_rdata, init_word(16));

    // Reset while the merge write is being presented.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h52; req_wdata = 32'h1234;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("merge_we_pre", 32'(mem_we), 32'd1);
    rst_n = 1'b0; #1;
    check_eq("rstmg_mem_we", 32'(mem_we), 32'd0);
    check_eq("rstmg_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    do_req(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 0);
    check_eq("rstmg_word_kept", last_rdata, init_word(20));

    // Random traffic over a small window plus occasional out-of-range words.
    for (int t = 0; t < 300; t++) begin
      w = $urandom_range(0, 63);
      if ($urandom_range(0, 15) == 0) w = $urandom_range(DEPTH, DEPTH + 100);
      a = (32'(w) << 2) | 32'($urandom_range(0, 3));
      do_req(1'($urandom), ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
             1'($urandom), a, $urandom, $urandom_range(0, 3));
    end

    // Final memory image against the reference.
    for (int i = 0; i < 64; i++) check_eq("final_mem", ram[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
